bin_to_bcd: RTL and testbench

Iterative binary-to-BCD converter using double dabble (shift-add-3), the forward direction of the existing BCD-to-binary path. Accepts a 16-bit unsigned binary word on an `init` pulse and produces a 5-digit packed BCD result after a fixed number of cycles. It signals completion with a one-cycle `done` pulse. It sits between binary arithmetic logic and display/BCD consumers and uses the same init/done handshake style as the rest of the conversion blocks.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bin_to_bcd_bit_counter.sv | 50 +++++
 rtl/bin_to_bcd.sv | 123 ++++++++++++
 tb/tb_bin_to_bcd.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: constants shared by the binary<->BCD conversion blocks.
//   state_t     - FSM encoding for the iterative converters
//   ADJ_THRESH  - digit value at or above which shift-add-3 applies the +3
//   ADJ_ADD     - amount added to an adjusted digit
//   DEF_N_BITS / DEF_N_DIGITS - default binary width and BCD digit count
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADJ   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] ADJ_THRESH = 4'd5;
   localparam logic [3:0] ADJ_ADD    = 4'd3;

   localparam int DEF_N_BITS   = 16;
   localparam int DEF_N_DIGITS = 5;

endpackage

// File: rtl/bin_to_bcd_bit_counter.sv
// bit_counter: iteration counter for the shift-add-3 converter.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset (count = N_BITS, z = 0)
//   load - reload the count with N_BITS
//   dec  - decrement the count by one
//   z    - registered terminal flag, high while the count equals 1, so the
//          shift that consumes the last binary bit can see it directly
module bit_counter
   import bcd_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic z
);

   localparam int CW = $clog2(N_BITS + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          z_q, z_d;

   always_comb begin
      cnt_d = cnt_q;
      z_d   = z_q;
      if (load) begin
         cnt_d = CW'(N_BITS);
         z_d   = (N_BITS == 1);
      end else if (dec) begin
         cnt_d = cnt_q - CW'(1);
         // The count after this decrement will be 1 exactly when it is 2 now.
         z_d   = (cnt_q == CW'(2));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= CW'(N_BITS);
         z_q   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         z_q   <= z_d;
      end
   end

   assign z = z_q;

endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: iterative binary-to-BCD converter (double dabble).
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, aborts any conversion
//   init    - start request, honoured only when idle
//   bin_in  - unsigned operand, captured on the accepted init
//   bcd_out - packed BCD result, digit 0 in bits [3:0]; held until next start
//   busy    - high from the cycle after acceptance through the done cycle
//   done    - one-cycle pulse, bcd_out valid in that cycle
// A conversion alternates ADJ and SHIFT for N_BITS iterations, so done
// appears 2*N_BITS+1 cycles after the accepting edge.
module bin_to_bcd
   import bcd_pkg::*;
#(
   parameter int N_BITS   = DEF_N_BITS,
   parameter int N_DIGITS = DEF_N_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init,
   input  logic [N_BITS-1:0]     bin_in,
   output logic [4*N_DIGITS-1:0] bcd_out,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = 4 * N_DIGITS;

   state_t          state_q, state_d;
   logic [N_BITS-1:0] bin_sh_q, bin_sh_d;
   logic [BW-1:0]   bcd_sh_q, bcd_sh_d;
   logic [BW-1:0]   bcd_out_q, bcd_out_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            cnt_load, cnt_dec, cnt_z;
   logic [BW-1:0]   adj_bcd;
   logic [BW+N_BITS-1:0] shifted;

   bit_counter #(.N_BITS(N_BITS)) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .dec  (cnt_dec),
      .z    (cnt_z)
   );

   // Digits never exceed 9 before the adjust, so +3 stays within 4 bits
   // and no carry crosses into the neighbouring digit.
   for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
      assign adj_bcd[4*gi +: 4] = (bcd_sh_q[4*gi +: 4] >= ADJ_THRESH)
                                  ? bcd_sh_q[4*gi +: 4] + ADJ_ADD
                                  : bcd_sh_q[4*gi +: 4];
   end

   assign shifted = {bcd_sh_q, bin_sh_q} << 1;

   always_comb begin
      state_d   = state_q;
      bin_sh_d  = bin_sh_q;
      bcd_sh_d  = bcd_sh_q;
      bcd_out_d = bcd_out_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state_q)
         IDLE: begin
            if (init) begin
               bin_sh_d  = bin_in;
               bcd_sh_d  = '0;
               bcd_out_d = '0;
               cnt_load  = 1'b1;
               state_d   = ADJ;
            end
         end
         ADJ: begin
            bcd_sh_d = adj_bcd;
            state_d  = SHIFT;
         end
         SHIFT: begin
            {bcd_sh_d, bin_sh_d} = shifted;
            cnt_dec = 1'b1;
            if (cnt_z) begin
               bcd_out_d = shifted[BW+N_BITS-1 -: BW];
               state_d   = DONE;
            end else begin
               state_d = ADJ;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Status flags are derived from the next state so they are registered
      // alongside it and line up with the state they describe.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bin_sh_q  <= '0;
         bcd_sh_q  <= '0;
         bcd_out_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_sh_q  <= bin_sh_d;
         bcd_sh_q  <= bcd_sh_d;
         bcd_out_q <= bcd_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bcd_out = bcd_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed and swept checks for bin_to_bcd with 16-bit input / 5 digits.
module tb_bin_to_bcd;
   import bcd_pkg::*;

   logic        clk;
   logic        rst;
   logic        init;
   logic [15:0] bin_in;
   logic [19:0] bcd_out;
   logic        busy;
   logic        done;

   int vectors;
   int miscompares;

   bin_to_bcd #(.N_BITS(16), .N_DIGITS(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .init    (init),
      .bin_in  (bin_in),
      .bcd_out (bcd_out),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Decimal digit extraction, independent of the shift-add-3 method.
   function automatic logic [19:0] ref_bcd(input logic [15:0] v);
      logic [19:0] r;
      int          x;
      x = int'(v);
      r = '0;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts a conversion at the current negedge and watches 40 cycles.
   // reinit_a/reinit_b: cycle indices (1 = first cycle after acceptance)
   // at which init is driven high again; scramble changes bin_in every cycle.
   task automatic run_conv(input string tag, input logic [15:0] val,
                           input logic [19:0] exp_bcd, input bit full,
                           input bit scramble, input int reinit_a,
                           input int reinit_b);
      int          busy_cnt;
      int          done_cnt;
      int          done_at;
      logic [19:0] got;
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = -1;
      got      = 'x;
      bin_in = val;
      init   = 1'b1;
      @(negedge clk);
      init = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = i;
               got     = bcd_out;
            end
         end
         init = (i == reinit_a || i == reinit_b);
         if (scramble) bin_in = 16'($urandom);
         @(negedge clk);
      end
      init = 1'b0;
      check({tag, "_bcd"}, 32'(got), 32'(exp_bcd));
      check({tag, "_done_at"}, 32'(done_at), 32'd33);
      if (full) begin
         check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
         check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
         check({tag, "_held"}, 32'(bcd_out), 32'(exp_bcd));
      end
      $display("conv %s bin=%0d bcd=%h done_at=%0d busy=%0d", tag, val, got, done_at, busy_cnt);
   endtask

   initial begin
      int          done_seen;
      int          busy_seen;
      logic [15:0] v;
      vectors     = 0;
      miscompares = 0;
      rst    = 1'b1;
      init   = 1'b0;
      bin_in = 16'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_bcd_out", 32'(bcd_out), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      check("reset_state", 32'(dut.state_q), 32'(IDLE));

      // Directed vectors, including the digit-adjust threshold edges.
      run_conv("zero",  16'd0,     20'h00000, 1'b1, 1'b0, -1, -1);
      run_conv("max",   16'd65535, 20'h65535, 1'b1, 1'b0, -1, -1);
      run_conv("d255",  16'd255,   20'h00255, 1'b1, 1'b0, -1, -1);
      run_conv("d10",   16'd10,    20'h00010, 1'b1, 1'b0, -1, -1);
      run_conv("d9",    16'd9,     20'h00009, 1'b1, 1'b0, -1, -1);
      run_conv("d5",    16'd5,     20'h00005, 1'b1, 1'b0, -1, -1);
      run_conv("d4",    16'd4,     20'h00004, 1'b1, 1'b0, -1, -1);
      run_conv("d59999",16'd59999, 20'h59999, 1'b1, 1'b0, -1, -1);

      // init during SHIFT/ADJ and during the DONE cycle must be ignored.
      run_conv("reinit", 16'd4321, 20'h04321, 1'b1, 1'b1, 10, 33);
      run_conv("reinit2",16'd8080, 20'h08080, 1'b1, 1'b1, 7, 33);

      // Abort at iteration 8 (cycle 16 after acceptance).
      bin_in = 16'd54321;
      init   = 1'b1;
      @(negedge clk);
      init = 1'b0;
      done_seen = 0;
      for (int i = 1; i < 16; i++) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_bcd_out", 32'(bcd_out), 32'h0);
      check("abort_state", 32'(dut.state_q), 32'(IDLE));
      $display("abort busy=%0d done=%0d bcd=%h", busy, done, bcd_out);
      run_conv("after_abort", 16'd1234, 20'h01234, 1'b1, 1'b0, -1, -1);

      // rst and init together: reset wins and nothing starts.
      rst    = 1'b1;
      init   = 1'b1;
      bin_in = 16'd77;
      @(negedge clk);
      rst  = 1'b0;
      init = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy !== 1'b0) busy_seen++;
         @(negedge clk);
      end
      check("rst_init_busy", 32'(busy_seen), 32'd0);
      check("rst_init_state", 32'(dut.state_q), 32'(IDLE));
      $display("rst_init busy_cycles=%0d", busy_seen);

      // Random sweep with bin_in scrambled after acceptance.
      for (int n = 0; n < 1000; n++) begin
         v = 16'($urandom);
         run_conv("rand", v, ref_bcd(v), 1'b0, 1'b1, -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
